fp_addsub_pipe: RTL and testbench
=================================

// Module: fp_addsub_pipe
// PURPOSE
//  Parametrised, pipelined IEEE-754 add/subtract unit with valid/ready flow control.
//  Correctly rounded (RNE), handles special values, reports exception flags.
//  Sits in the FP execute lane next to the FP multiplier; tag returns with each result.
// PARAMETERS
//  EXP_W  8   exponent field width (bias = 2**(EXP_W-1)-1)
//  MAN_W  23  stored mantissa width (hidden bit implied)
//  TAG_W  4   opaque tag width, carried with each operation
// PORTS
//  clk        in   1              rising-edge clock
//  resetn     in   1              asynchronous active-low reset
//  in_valid   in   1              operation presented
//  in_ready   out  1              unit accepts operation this cycle
//  op_sub     in   1              1: a-b, 0: a+b
//  a, b       in   1+EXP_W+MAN_W  operands {sign,exp,man}
//  tag_in     in   TAG_W          tag for this operation
//  out_valid  out  1              result presented
//  out_ready  in   1              consumer accepts result
//  result     out  1+EXP_W+MAN_W  rounded sum
//  tag_out    out  TAG_W          tag of the presented result
//  flags      out  4              {invalid, overflow, underflow, inexact}
// BEHAVIOUR
//  Reset: all stage valids 0; out_valid=0, result=0, tag_out=0, flags=0. Reset mid-flight drops all ops.
//  Pipeline: 4 stages, latency exactly 4 cycles with out_ready held high; throughput 1/cycle.
//   S1 unpack, b sign ^= op_sub, swap so |x|>=|y|, align y right, keep guard/round/sticky.
//   S2 mantissa add (like signs) or subtract (unlike signs); carry-out kept.
//   S3 normalise: carry -> shift right 1, exp+1; else left shift by fp_lzc count, clamp at exp=1.
//   S4 RNE round (carry may bump exponent), overflow check, pack.
//  Handshake: global stall; in_ready = !out_valid | out_ready. Stall freezes every stage.
//   Transfer in when in_valid&in_ready; out when out_valid&out_ready. result/tag/flags stable while stalled.
//   Bubbles propagate; order strictly preserved.
//  Sign: larger magnitude wins; exact zero sum of unlike signs -> +0; (-0)+(-0) -> -0.
//  Specials (resolved in S1, carried as bypass): any NaN -> canonical qNaN (exp all 1s, man MSB 1),
//   invalid=1 only if an input is sNaN; inf + -inf -> qNaN, invalid=1; inf op finite -> inf, no flags.
//  Overflow: rounded exp >= all-ones -> signed inf, overflow=1, inexact=1.
//  inexact = any of guard/round/sticky nonzero after normalise. Shift >= MAN_W+3 -> y collapses to sticky.
// CONFIGURATION
//  FPADD_SUBNORM_EN defined: subnormal inputs use hidden bit 0, exp treated as 1; tiny results
//   stay subnormal; underflow=1 when result tiny and inexact.
//  Not defined: subnormal inputs flushed to signed zero; tiny results flushed to signed zero with
//   underflow=1, inexact=1. Latency unchanged in both builds.
// STRUCTURE
//  fp_pkg: EXP_W/MAN_W defaults, bias function, canonical qNaN constant, flag bit indices,
//   unpacked-operand struct {sign, exp, man, is_zero, is_inf, is_nan, is_snan}.
//  Sub-module fp_lzc (parametrised leading-zero counter, combinational) used in S3.
// TESTING (EXP_W=8, MAN_W=23)
//  3F800000+40000000 -> 40400000, flags 0, out 4 cycles after accept.
//  3F800000-3F800000 (op_sub=1) -> 00000000, flags 0; BF800000+BF800000 -> C0000000.
//  7F800000+FF800000 -> 7FC00000 invalid=1; 7F800001+3F800000 -> 7FC00000 invalid=1.
//  7F7FFFFF+7F7FFFFF -> 7F800000 overflow=1 inexact=1.
//  3F800000+33800000 -> 3F800000 inexact=1 (tie to even); 3F800000+33800001 -> 3F800001 inexact=1.
//  00000001+00000001 -> 00000002 with FPADD_SUBNORM_EN; 00000000 without.
//  Stream 8 tagged ops, out_ready low 3 cycles mid-stream: no loss/duplication, tags in order,
//   outputs stable during stall; assert resetn low mid-stream -> out_valid 0 immediately.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared floating-point definitions for the FP execute lane.
//  - default field widths (binary32)
//  - exponent bias helper and canonical quiet-NaN generator
//  - exception flag bit positions within the 4-bit flags vector
//  - unpacked-operand record used by FP units
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  // flags = {invalid, overflow, underflow, inexact}
  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W:0]   man;   // hidden bit included
    logic                is_zero;
    logic                is_inf;
    logic                is_nan;
    logic                is_snan;
  } fp_unp_t;

  function automatic int fp_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // Canonical qNaN: sign 0, exponent all ones, mantissa MSB set, rest 0.
  function automatic logic [63:0] fp_qnan(input int ew, input int mw);
    return (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter.
//  in_i  [W-1:0]            value to scan (MSB first)
//  cnt_o [$clog2(W+1)-1:0]  number of leading zeros; W when in_i == 0
module fp_lzc #(
  parameter int W = 27
) (
  input  logic [W-1:0]           in_i,
  output logic [$clog2(W+1)-1:0] cnt_o
);
  localparam int CW = $clog2(W + 1);

  // Scan LSB->MSB so the highest set bit is the last one to write.
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++)
      if (in_i[i]) cnt_o = CW'(W - 1 - i);
  end
endmodule

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 4-stage IEEE-754 add/subtract, RNE rounding, global-stall
// valid/ready flow control. A result leaves 4 clocks after it is accepted
// (the accepting edge is the first). A tag rides along with each operation.
//  clk, resetn          clock, asynchronous active-low reset
//  in_valid/in_ready    operation handshake (op_sub, a, b, tag_in)
//  out_valid/out_ready  result handshake (result, tag_out, flags)
//  flags                {invalid, overflow, underflow, inexact}
// Build option: FPADD_SUBNORM_EN keeps subnormals (inputs and results);
// without it subnormal inputs and tiny results flush to signed zero.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op_sub,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic [TAG_W-1:0]       tag_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [TAG_W-1:0]       tag_out,
  output logic [3:0]             flags
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int SW     = MAN_W + 4;           // hidden + man + guard/round/sticky
  localparam int SH_W   = $clog2(SW + 1);
  localparam int LZ_W   = $clog2(SW + 1);
  localparam int STAGES = 4;
  localparam int EMAX   = (1 << EXP_W) - 1;
  localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;   // effective exponent (>= 1)
    logic [MAN_W:0]   sig;
    logic             is_inf;
    logic             is_nan;
    logic             is_snan;
  } unp_t;

  typedef struct packed {
    logic         v;
    logic         inv;
    logic [W-1:0] res;
  } byp_t;

  typedef struct packed {
    logic             sx;
    logic             sub;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]    mx;
    logic [SW-1:0]    my;
    byp_t             byp;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SW:0]      sum;
    byp_t             byp;
    logic [TAG_W-1:0] tag;
  } s2_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W:0]   exp;   // extra bit so carry/round bumps cannot wrap
    logic [SW-1:0]    mn;
    byp_t             byp;
    logic [TAG_W-1:0] tag;
  } s3_t;

  // Zero and subnormal encodings share effective exponent 1 so alignment
  // against normals needs no special case.
  function automatic unp_t fp_unpack(input logic [W-1:0] v);
    unp_t             u;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e = v[W-2:MAN_W];
    m = v[MAN_W-1:0];
    u.sign    = v[W-1];
    u.exp     = (e == '0) ? EXP_W'(1) : e;
    u.is_inf  = (e == '1) && (m == '0);
    u.is_nan  = (e == '1) && (m != '0);
    u.is_snan = u.is_nan && !m[MAN_W-1];
`ifdef FPADD_SUBNORM_EN
    u.sig = {e != '0, m};
`else
    u.sig = (e == '0) ? '0 : {1'b1, m};
`endif
    return u;
  endfunction

  // ---------------- handshake / valid pipe ----------------
  logic [STAGES:1] vld_q;
  logic [STAGES:0] vld_pipe;
  logic            adv;

  assign in_ready  = !vld_pipe[STAGES] | out_ready;
  assign adv       = in_ready;   // global stall: nothing moves while output is blocked
  assign vld_pipe  = {vld_q, in_valid & in_ready};
  assign out_valid = vld_pipe[STAGES];

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  logic [W-1:0]     res_d, res_q;
  logic [3:0]       flg_d, flg_q;
  logic [TAG_W-1:0] tag_q;

  // ---------------- S1: unpack, swap, align, specials ----------------
  unp_t             ua, ub;
  logic             swap;
  logic [EXP_W-1:0] ex, ey, ediff;
  logic [MAN_W:0]   mx, my;
  logic [SH_W-1:0]  ash;
  logic [2*SW-1:0]  y_wide;
  byp_t             byp1;

  always_comb begin
    ua = fp_unpack(a);
    ub = fp_unpack(b);
    ub.sign = b[W-1] ^ op_sub;
    swap = {ub.exp, ub.sig} > {ua.exp, ua.sig};
    ex   = swap ? ub.exp : ua.exp;
    ey   = swap ? ua.exp : ub.exp;
    mx   = swap ? ub.sig : ua.sig;
    my   = swap ? ua.sig : ub.sig;
    ediff = ex - ey;
    // Beyond SW positions y is entirely sticky; clamp keeps the shifter small.
    ash    = (32'(ediff) >= SW) ? SH_W'(SW) : SH_W'(ediff);
    y_wide = {my, 3'b000, {SW{1'b0}}} >> ash;

    s1_d.sx  = swap ? ub.sign : ua.sign;
    s1_d.sub = ua.sign ^ ub.sign;
    s1_d.exp = ex;
    s1_d.mx  = {mx, 3'b000};
    s1_d.my  = y_wide[2*SW-1:SW] | SW'(|y_wide[SW-1:0]);
    s1_d.tag = tag_in;

    byp1.v   = 1'b1;
    byp1.inv = ua.is_snan | ub.is_snan;
    byp1.res = QNAN;
    if (ua.is_nan | ub.is_nan) begin
      // qNaN already selected; invalid only from a signalling input
    end else if (ua.is_inf & ub.is_inf & (ua.sign != ub.sign)) begin
      byp1.inv = 1'b1;
    end else if (ua.is_inf) begin
      byp1.res = {ua.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ub.is_inf) begin
      byp1.res = {ub.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      byp1.v = 1'b0;
    end
    s1_d.byp = byp1;
  end

  // ---------------- S2: magnitude add / subtract ----------------
  always_comb begin
    s2_d.sum = s1_q.sub ? ({1'b0, s1_q.mx} - {1'b0, s1_q.my})
                        : ({1'b0, s1_q.mx} + {1'b0, s1_q.my});
    // Exact cancellation gives +0; like-signed zeros keep their sign.
    s2_d.sign = (s2_d.sum == '0) ? (s1_q.sx & ~s1_q.sub) : s1_q.sx;
    s2_d.exp  = s1_q.exp;
    s2_d.byp  = s1_q.byp;
    s2_d.tag  = s1_q.tag;
  end

  // ---------------- S3: normalise ----------------
  logic [LZ_W-1:0] lz;
  logic [31:0]     lim, nsh;

  fp_lzc #(.W(SW)) u_lzc (
    .in_i  (s2_q.sum[SW-1:0]),
    .cnt_o (lz)
  );

  always_comb begin
    s3_d.sign = s2_q.sign;
    s3_d.byp  = s2_q.byp;
    s3_d.tag  = s2_q.tag;
    // Left shift stops at exp=1 so tiny results land in subnormal form.
    lim = 32'(s2_q.exp) - 32'd1;
    nsh = (32'(lz) > lim) ? lim : 32'(lz);
    if (s2_q.sum[SW]) begin
      s3_d.mn  = {s2_q.sum[SW:2], |s2_q.sum[1:0]};
      s3_d.exp = {1'b0, s2_q.exp} + (EXP_W+1)'(1);
    end else begin
      s3_d.mn  = s2_q.sum[SW-1:0] << nsh;
      s3_d.exp = {1'b0, s2_q.exp} - (EXP_W+1)'(nsh);
    end
  end

  // ---------------- S4: round, range check, pack ----------------
  logic [MAN_W+1:0] mr;
  logic [MAN_W:0]   mf;
  logic [EXP_W:0]   ef;
  logic             inx, rup, hid, ovf, tiny;

  always_comb begin
    inx = |s3_q.mn[2:0];
    rup = s3_q.mn[2] & (s3_q.mn[1] | s3_q.mn[0] | s3_q.mn[3]);
    mr  = {1'b0, s3_q.mn[SW-1:3]} + (MAN_W+2)'(rup);
    if (mr[MAN_W+1]) begin
      mf = mr[MAN_W+1:1];
      ef = s3_q.exp + (EXP_W+1)'(1);
    end else begin
      mf = mr[MAN_W:0];
      ef = s3_q.exp;
    end
    hid  = mf[MAN_W];
    ovf  = hid & (ef >= (EXP_W+1)'(EMAX));
    tiny = ~hid & (mf != '0);
    // Hidden bit clear means exp is 1 in subnormal form: field encodes 0.
    res_d = {s3_q.sign, hid ? ef[EXP_W-1:0] : {EXP_W{1'b0}}, mf[MAN_W-1:0]};
    flg_d = '0;
    flg_d[FLG_INX] = inx;
    if (s3_q.byp.v) begin
      res_d = s3_q.byp.res;
      flg_d = '0;
      flg_d[FLG_INV] = s3_q.byp.inv;
    end else if (ovf) begin
      res_d = {s3_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_d[FLG_OVF] = 1'b1;
      flg_d[FLG_INX] = 1'b1;
    end else if (tiny) begin
`ifdef FPADD_SUBNORM_EN
      flg_d[FLG_UNF] = inx;
`else
      res_d = {s3_q.sign, {(W-1){1'b0}}};
      flg_d[FLG_UNF] = 1'b1;
      flg_d[FLG_INX] = 1'b1;
`endif
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      res_q <= '0;
      flg_q <= '0;
      tag_q <= '0;
    end else if (adv) begin
      vld_q <= vld_pipe[STAGES-1:0];
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      res_q <= res_d;
      flg_q <= flg_d;
      tag_q <= s3_q.tag;
    end
  end

  assign result  = res_q;
  assign flags   = flg_q;
  assign tag_out = tag_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe (binary32): vector table with
// hand-computed results, then a stalled 8-op stream and a mid-flight reset.
module tb_fp_addsub_pipe;
  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_sub = 1'b0;
  logic [31:0] a = '0, b = '0, result;
  logic [3:0]  tag_in = '0, tag_out, flags;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .a(a), .b(b), .tag_in(tag_in), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .tag_out(tag_out), .flags(flags)
  );

  typedef struct {
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  vec_t vt[$];

  task automatic addv(input logic s, input logic [31:0] va, input logic [31:0] vb,
                      input logic [31:0] vr, input logic [3:0] vf);
    vec_t v;
    v.sub = s; v.a = va; v.b = vb; v.r = vr; v.f = vf;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // 1.0 .. 9.0 in binary32, index = value
  logic [31:0] fb [0:9] = '{32'h0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

  initial begin
    int n, got, idx, cyc, drop;
    logic acc, prev_stall;
    logic [31:0] held_r;
    logic [3:0]  held_t, held_f;

    // flags = {invalid, overflow, underflow, inexact}
    addv(0, 32'h3F800000, 32'h40000000, 32'h40400000, 4'h0);
    addv(1, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'h0);
    addv(0, 32'hBF800000, 32'hBF800000, 32'hC0000000, 4'h0);
    addv(0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'h8);
    addv(0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'h8);
    addv(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'h5);
    addv(0, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'h1);
    addv(0, 32'h3F800000, 32'h33800001, 32'h3F800001, 4'h1);
`ifdef FPADD_SUBNORM_EN
    addv(0, 32'h00000001, 32'h00000001, 32'h00000002, 4'h0);
    addv(0, 32'h00800001, 32'h80800000, 32'h00000001, 4'h0);
`else
    addv(0, 32'h00000001, 32'h00000001, 32'h00000000, 4'h0);
    addv(0, 32'h00800001, 32'h80800000, 32'h00000000, 4'h3);
`endif
    addv(0, 32'h80000000, 32'h80000000, 32'h80000000, 4'h0);
    addv(0, 32'h80000000, 32'h00000000, 32'h00000000, 4'h0);
    addv(0, 32'h3F800000, 32'hBF800000, 32'h00000000, 4'h0);
    addv(1, 32'h40000000, 32'h3F800000, 32'h3F800000, 4'h0);
    addv(1, 32'h3F800000, 32'h40000000, 32'hBF800000, 4'h0);
    addv(0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'h0);
    addv(0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 4'h0);
    addv(1, 32'h3F800000, 32'h7F800000, 32'hFF800000, 4'h0);
    addv(1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'h8);
    addv(0, 32'h3FFFFFFF, 32'h3F800000, 32'h40400000, 4'h1);
    addv(1, 32'h3F800001, 32'h3F800000, 32'h34000000, 4'h0);
    addv(0, 32'h7F7FFFFF, 32'h73000000, 32'h7F800000, 4'h5);

    // reset state
    #1 resetn = 1'b0;
    #2;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst tag", 32'(tag_out), 32'd0);
    chk("rst flags", 32'(flags), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    #9 resetn = 1'b1;
    @(posedge clk); #1;

    // table: one op at a time, latency, value, flags, tag
    for (int i = 0; i < vt.size(); i++) begin
      op_sub = vt[i].sub; a = vt[i].a; b = vt[i].b; tag_in = 4'(i); in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 12) begin
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("v%0d latency", i), 32'(n), 32'd4);
      chk($sformatf("v%0d result", i), result, vt[i].r);
      chk($sformatf("v%0d flags", i), 32'(flags), 32'(vt[i].f));
      chk($sformatf("v%0d tag", i), 32'(tag_out), 32'(i % 16));
    end
    @(posedge clk); #1;

    // 8-op stream, out_ready low for 3 cycles once results flow
    got = 0; idx = 0; cyc = 0; prev_stall = 1'b0;
    held_r = '0; held_t = '0; held_f = '0;
    op_sub = 1'b0;
    while (got < 8 && cyc < 60) begin
      out_ready = !(cyc >= 5 && cyc < 8);
      if (idx < 8) begin
        in_valid = 1'b1; a = fb[idx+1]; b = fb[1]; tag_in = 4'(idx);
      end else begin
        in_valid = 1'b0;
      end
      #3;
      if (prev_stall) begin
        chk("stall valid", 32'(out_valid), 32'd1);
        chk("stall result", result, held_r);
        chk("stall tag", 32'(tag_out), 32'(held_t));
        chk("stall flags", 32'(flags), 32'(held_f));
      end
      prev_stall = out_valid & !out_ready;
      if (prev_stall) begin
        held_r = result; held_t = tag_out; held_f = flags;
        chk("stall in_ready", 32'(in_ready), 32'd0);
      end
      if (out_valid & out_ready) begin
        chk($sformatf("s%0d result", got), result, fb[got+2]);
        chk($sformatf("s%0d tag", got), 32'(tag_out), 32'(got));
        got++;
      end
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream count", 32'(got), 32'd8);
    drop = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) drop++;
    end
    chk("stream extra", 32'(drop), 32'd0);

    // mid-flight reset drops everything, output clears at once
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = fb[2]; b = fb[3]; tag_in = 4'(9 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre-reset valid", 32'(out_valid), 32'd1);
    resetn = 1'b0;
    #1;
    chk("mid-reset valid", 32'(out_valid), 32'd0);
    chk("mid-reset result", result, 32'd0);
    chk("mid-reset tag", 32'(tag_out), 32'd0);
    #2 resetn = 1'b1;
    drop = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) drop++;
    end
    chk("post-reset drop", 32'(drop), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
